// File: rtl/bht_update_ctrl_pkg.sv
// Shared definitions for the branch history table update path.
// Holds the default index width, the 65-bit update entry layout with its field
// offsets, the controller state encodings and a small entry packing helper.
package bht_update_ctrl_pkg;

  // Default table index width; the table instance uses the same value.
  localparam int BHT_INDEX_LEN = 8;

  // Update entry layout {pc[31:0], target[31:0], taken}.
  localparam int ENT_W          = 65;
  localparam int ENT_TAKEN_LSB  = 0;
  localparam int ENT_TARGET_LSB = 1;
  localparam int ENT_PC_LSB     = 33;

  // Controller states: SWEEP initialises every table index, RUN forwards updates.
  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } bht_state_t;

  // Builds one update entry from its fields.
  function automatic logic [ENT_W-1:0] bht_pack_ent(input logic [31:0] pc,
                                                    input logic [31:0] target,
                                                    input logic        taken);
    logic [ENT_W-1:0] ent;
    ent                          = '0;
    ent[ENT_PC_LSB +: 32]        = pc;
    ent[ENT_TARGET_LSB +: 32]    = target;
    ent[ENT_TAKEN_LSB]           = taken;
    return ent;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Purpose: in-order update buffer, up to two writes and one read per cycle, with count.
// Latency: a write is visible at rd_dat the cycle after it is written; no write-to-read bypass.
// Backpressure: none internally; the caller must only write when enough free slots exist.
module bht_upd_fifo
  import bht_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 wr_n,
  input  logic [W-1:0]               wr_a_dat,
  input  logic [W-1:0]               wr_b_dat,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("bht_upd_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_a_en;
  logic             wr_b_en;

  // Slot A is the older entry; slot B is only written when two arrive together.
  assign wr_a_en = (wr_n != 2'd0);
  assign wr_b_en = (wr_n == 2'd2);
  assign rd_dat  = mem[rd_ptr];

  // Storage writes; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_a_en) mem[wr_ptr] <= wr_a_dat;
    if (wr_b_en) mem[wr_ptr + PTR_W'(1)] <= wr_b_dat;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_n);
      rd_ptr <= rd_ptr + PTR_W'(rd_en);
      count  <= count + CNT_W'(wr_n) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// Purpose: orders branch updates from two pipes into the BHT's single write port (BHT_INIT_SWEEP_EN adds a post-reset index sweep).
// Latency: an update accepted in cycle N is presented to the table at the earliest in cycle N+1.
// Backpressure: upd_ready low when fewer than two slots are free; valid requests seen then are dropped and counted.
module bht_update_ctrl
  import bht_update_ctrl_pkg::*;
#(
  parameter int INDEX_LEN = BHT_INDEX_LEN,
  parameter int DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_pc,
  input  logic [31:0] req0_target,
  input  logic        req0_taken,
  input  logic        req1_valid,
  input  logic [31:0] req1_pc,
  input  logic [31:0] req1_target,
  input  logic        req1_taken,
  output logic        upd_ready,
  output logic        br_update,
  output logic [31:0] br_pc,
  output logic [31:0] br_target,
  output logic        br_is,
  output logic        init_busy,
  output logic [15:0] drop_cnt
);

  localparam int CNT_W = $clog2(DEPTH+1);

  if ((INDEX_LEN < 1) || (INDEX_LEN > 30)) begin : g_bad_index_len
    $error("bht_update_ctrl: INDEX_LEN must be in 1..30");
  end

  bht_state_t       state;
  logic             sweeping;
  logic [31:0]      sweep_pc;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] wr_a_dat;
  logic [ENT_W-1:0] wr_b_dat;
  logic [1:0]       n_req;
  logic [1:0]       n_enq;
  logic [1:0]       n_drop;
  logic             pop;
  logic [16:0]      drop_sum;
  logic             strobe_q;
  logic [31:0]      hold_pc;
  logic [31:0]      hold_target;
  logic             hold_is;

`ifdef BHT_INIT_SWEEP_EN
  bht_state_t           state_next;
  logic [INDEX_LEN-1:0] idx;
  logic [INDEX_LEN-1:0] idx_next;

  // State and sweep index register; every reset restarts the sweep at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SWEEP;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Walk one index per cycle, move to RUN once the last index has been issued.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      ST_SWEEP: begin
        idx_next = idx + 1'b1;
        if (idx == '1) state_next = ST_RUN;
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  assign sweep_pc = 32'({idx, 2'b00});
`else
  assign state    = ST_RUN;
  assign sweep_pc = '0;
`endif

  assign sweeping  = (state == ST_SWEEP);
  assign init_busy = sweeping;

  // Two free slots are required so a dual request is never split.
  assign upd_ready = !sweeping && (count <= CNT_W'(DEPTH - 2));

  assign n_req  = {1'b0, req0_valid} + {1'b0, req1_valid};
  assign n_enq  = upd_ready ? n_req : 2'd0;
  assign n_drop = upd_ready ? 2'd0 : n_req;

  // Compact the pair so the older valid request always lands in slot A.
  assign wr_a_dat = req0_valid ? bht_pack_ent(req0_pc, req0_target, req0_taken)
                               : bht_pack_ent(req1_pc, req1_target, req1_taken);
  assign wr_b_dat = bht_pack_ent(req1_pc, req1_target, req1_taken);

  // Head is only popped when it was already present at the start of the cycle.
  assign pop = !sweeping && (count != '0);

  bht_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_n     (n_enq),
    .wr_a_dat (wr_a_dat),
    .wr_b_dat (wr_b_dat),
    .rd_en    (pop),
    .rd_dat   (head),
    .count    (count)
  );

  // Saturating sum of dropped requests for this cycle.
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
  end

  // Drop counter, cleared by reset and pinned at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (n_drop != 2'd0) begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Sweep writes are registered here; popped entries are latched so the
  // table-side data holds its last value while the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q    <= 1'b0;
      hold_pc     <= '0;
      hold_target <= '0;
      hold_is     <= 1'b0;
    end else begin
      strobe_q <= sweeping;
      if (sweeping) begin
        hold_pc     <= sweep_pc;
        hold_target <= sweep_pc + 32'd8;
        hold_is     <= 1'b1;
      end else if (pop) begin
        hold_pc     <= head[ENT_PC_LSB +: 32];
        hold_target <= head[ENT_TARGET_LSB +: 32];
        hold_is     <= head[ENT_TAKEN_LSB];
      end
    end
  end

  // Table port is driven only from state: buffered head when present, else held data.
  assign br_update = strobe_q | pop;
  assign br_pc     = pop ? head[ENT_PC_LSB +: 32]     : hold_pc;
  assign br_target = pop ? head[ENT_TARGET_LSB +: 32] : hold_target;
  assign br_is     = pop ? head[ENT_TAKEN_LSB]        : hold_is;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl with INDEX_LEN=2, DEPTH=4.
// Sweep-specific checks follow BHT_INIT_SWEEP_EN as seen by this file.
module tb_bht_update_ctrl;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [31:0] req0_pc;
  logic [31:0] req0_target;
  logic        req0_taken;
  logic        req1_valid;
  logic [31:0] req1_pc;
  logic [31:0] req1_target;
  logic        req1_taken;
  logic        upd_ready;
  logic        br_update;
  logic [31:0] br_pc;
  logic [31:0] br_target;
  logic        br_is;
  logic        init_busy;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;

  bht_update_ctrl #(
    .INDEX_LEN (2),
    .DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_pc     (req0_pc),
    .req0_target (req0_target),
    .req0_taken  (req0_taken),
    .req1_valid  (req1_valid),
    .req1_pc     (req1_pc),
    .req1_target (req1_target),
    .req1_taken  (req1_taken),
    .upd_ready   (upd_ready),
    .br_update   (br_update),
    .br_pc       (br_pc),
    .br_target   (br_target),
    .br_is       (br_is),
    .init_busy   (init_busy),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] pc0, input logic [31:0] tg0, input logic tk0,
                       input logic v1, input logic [31:0] pc1, input logic [31:0] tg1, input logic tk1);
    req0_valid  = v0;
    req0_pc     = pc0;
    req0_target = tg0;
    req0_taken  = tk0;
    req1_valid  = v1;
    req1_pc     = pc1;
    req1_target = tg1;
    req1_taken  = tk1;
  endtask

  // Expected table output for the 6-cycle saturation burst, indexed by cycle.
  logic [31:0] t4_pc  [0:9] = '{32'h0, 32'h4000, 32'h4008, 32'h4010, 32'h4018,
                                32'h4030, 32'h4038, 32'h4050, 32'h4058, 32'h0};
  logic        t4_rdy [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] t3_pc  [0:5] = '{32'h0, 32'h100, 32'h200, 32'h100, 32'h200, 32'h200};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset state
    check("rst_br_update", 32'(br_update), 0);
    check("rst_br_pc", br_pc, 0);
    check("rst_br_target", br_target, 0);
    check("rst_br_is", 32'(br_is), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
`ifdef BHT_INIT_SWEEP_EN
    check("rst_upd_ready", 32'(upd_ready), 0);
`else
    check("rst_upd_ready", 32'(upd_ready), 1);
    check("rst_init_busy", 32'(init_busy), 0);
`endif
    rst = 1'b0;

`ifdef BHT_INIT_SWEEP_EN
    // Sweep of 4 indices; a request during the sweep is dropped.
    check("sweep_busy", 32'(init_busy), 1);
    check("sweep_rdy", 32'(upd_ready), 0);
    drive(1, 32'h9000, 32'h9100, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    exp_drop = 1;
    check("sweep_drop", 32'(drop_cnt), 1);
    for (int i = 0; i < 4; i++) begin
      check("sweep_upd", 32'(br_update), 1);
      check("sweep_pc", br_pc, 32'(i * 4));
      check("sweep_target", br_target, 32'(i * 4 + 8));
      check("sweep_is", 32'(br_is), 1);
      tick();
    end
    check("sweep_done_upd", 32'(br_update), 0);
    check("sweep_done_busy", 32'(init_busy), 0);
    check("sweep_done_rdy", 32'(upd_ready), 1);
    tick();
    check("sweep_no_leak", 32'(br_update), 0);
`endif

    // Single request, one-cycle latency, no bypass in the accept cycle.
    drive(1, 32'h1000, 32'h2000, 1, 0, 0, 0, 0);
    check("t2_no_bypass", 32'(br_update), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_upd", 32'(br_update), 1);
    check("t2_pc", br_pc, 32'h1000);
    check("t2_target", br_target, 32'h2000);
    check("t2_is", 32'(br_is), 1);
    tick();
    check("t2_idle_upd", 32'(br_update), 0);
    check("t2_hold_pc", br_pc, 32'h1000);

    // Dual requests for two cycles: order 0x100, 0x200, 0x100, 0x200.
    for (int k = 0; k < 6; k++) begin
      if (k < 2) drive(1, 32'h100, 32'h140, 0, 1, 32'h200, 32'h240, 1);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      if (k == 1) check("t3_rdy", 32'(upd_ready), 1);
      check("t3_upd", 32'(br_update), (k >= 1 && k <= 4) ? 1 : 0);
      if (k >= 1) begin
        check("t3_pc", br_pc, t3_pc[k]);
        check("t3_target", br_target, t3_pc[k] + 32'h40);
        check("t3_is", 32'(br_is), (t3_pc[k] == 32'h200) ? 1 : 0);
      end
      tick();
    end
    check("t3_drop", 32'(drop_cnt), 32'(exp_drop));

    // Dual requests for six cycles: cycles 2 and 4 are refused.
    for (int k = 0; k < 10; k++) begin
      if (k < 6) drive(1, 32'h4000 + 32'(k * 16), 32'h4100 + 32'(k * 16), 1,
                       1, 32'h4008 + 32'(k * 16), 32'h4108 + 32'(k * 16), 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      if (k < 6) check("t4_rdy", 32'(upd_ready), 32'(t4_rdy[k]));
      check("t4_upd", 32'(br_update), (k >= 1 && k <= 8) ? 1 : 0);
      if (k >= 1 && k <= 8) begin
        check("t4_pc", br_pc, t4_pc[k]);
        check("t4_target", br_target, t4_pc[k] + 32'h100);
      end
      tick();
    end
    exp_drop += 4;
    check("t4_drop", 32'(drop_cnt), 32'(exp_drop));

    // Reset with three entries queued discards them and clears the counter.
    drive(1, 32'h7000, 32'h7400, 1, 1, 32'h7100, 32'h7500, 1);
    tick();
    drive(1, 32'h7200, 32'h7600, 1, 1, 32'h7300, 32'h7700, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_pre_upd", 32'(br_update), 1);
    check("t5_pre_pc", br_pc, 32'h7100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_upd", 32'(br_update), 0);
    check("t5_drop", 32'(drop_cnt), 0);
    for (int k = 0; k < 8; k++) begin
      check("t5_no_leak", 32'(br_update && (br_pc[31:4] != 28'h0)), 0);
      tick();
    end
    check("t5_rdy", 32'(upd_ready), 1);
    check("t5_busy", 32'(init_busy), 0);
    check("t5_drop_end", 32'(drop_cnt), 0);
    check("t5_idle", 32'(br_update), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
